// File: rtl/axi_slice_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_slice_pkg
// Desc    : Shared modes, AXI field widths and payload sizing for the slice.
// Rev     : 1.0 - initial release
// ============================================================================
package axi_slice_pkg;

   typedef enum logic [1:0] {
      SLC_BYPASS = 2'd0,
      SLC_FWD    = 2'd1,
      SLC_FULL   = 2'd2
   } slice_mode_e;

   typedef enum logic [2:0] {
      CH_AW = 3'd0,
      CH_W  = 3'd1,
      CH_B  = 3'd2,
      CH_AR = 3'd3,
      CH_R  = 3'd4
   } axi_chan_e;

   localparam int AXI_LEN_W  = 8;
   localparam int AXI_SIZE_W = 3;
   localparam int AXI_RESP_W = 2;

   function automatic int payload_w(axi_chan_e ch, int id_w, int addr_w, int data_w);
      case (ch)
         CH_AW, CH_AR: payload_w = id_w + addr_w + AXI_LEN_W + AXI_SIZE_W;
         CH_W:         payload_w = data_w + data_w / 8 + 1;
         CH_B:         payload_w = id_w + AXI_RESP_W;
         default:      payload_w = id_w + data_w + AXI_RESP_W + 1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_if.sv
`default_nettype none
// ============================================================================
// Interface : axi_if
// Desc      : AXI4 five-channel bundle with master/slave views.
// Rev       : 1.0 - initial release
// ============================================================================
interface axi_if #(
   parameter int ID_W   = 6,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
) ();
   import axi_slice_pkg::*;

   logic [ID_W-1:0]       awid;
   logic [ADDR_W-1:0]     awaddr;
   logic [AXI_LEN_W-1:0]  awlen;
   logic [AXI_SIZE_W-1:0] awsize;
   logic                  awvalid, awready;

   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast, wvalid, wready;

   logic [ID_W-1:0]       bid;
   logic [AXI_RESP_W-1:0] bresp;
   logic                  bvalid, bready;

   logic [ID_W-1:0]       arid;
   logic [ADDR_W-1:0]     araddr;
   logic [AXI_LEN_W-1:0]  arlen;
   logic [AXI_SIZE_W-1:0] arsize;
   logic                  arvalid, arready;

   logic [ID_W-1:0]       rid;
   logic [DATA_W-1:0]     rdata;
   logic [AXI_RESP_W-1:0] rresp;
   logic                  rlast, rvalid, rready;

   modport master (
      output awid, awaddr, awlen, awsize, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );

endinterface
`default_nettype wire

// File: rtl/axi_reg_stage.sv
`default_nettype none
// ============================================================================
// Module : axi_reg_stage
// Desc   : One valid/ready pipeline stage: bypass, forward register or full skid.
// Rev    : 1.0 - initial release
// ============================================================================
module axi_reg_stage #(
   parameter int PAYLOAD_W = 8,
   parameter int MODE      = 2
) (
   input  wire                  aclk,
   input  wire                  aresetn,
   input  wire                  in_valid,
   output logic                 in_ready,
   input  wire [PAYLOAD_W-1:0]  in_data,
   output logic                 out_valid,
   input  wire                  out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic                 empty
);
   import axi_slice_pkg::*;

   generate
      if (MODE == int'(SLC_BYPASS)) begin : g_bypass
         logic w_unused_clk;
         assign w_unused_clk = aclk ^ aresetn;
         assign out_valid    = in_valid;
         assign out_data     = in_data;
         assign in_ready     = out_ready;
         assign empty        = 1'b1;
      end else if (MODE == int'(SLC_FWD)) begin : g_fwd
         logic                 r_valid;
         logic [PAYLOAD_W-1:0] r_data;

         assign in_ready  = out_ready || !r_valid;
         assign out_valid = r_valid;
         assign out_data  = r_data;
         assign empty     = !r_valid;

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)      r_valid <= 1'b0;
            else if (in_ready) r_valid <= in_valid;
         end

         always_ff @(posedge aclk) begin
            if (in_valid && in_ready) r_data <= in_data;
         end
      end else begin : g_full
         logic                 r_main_valid, r_skid_valid, r_in_ready;
         logic [PAYLOAD_W-1:0] r_main_data, r_skid_data;
         logic                 w_accept, w_main_load;

         assign w_accept    = in_valid && r_in_ready;
         assign w_main_load = out_ready || !r_main_valid;
         assign in_ready    = r_in_ready;
         assign out_valid   = r_main_valid;
         assign out_data    = r_main_data;
         assign empty       = !r_main_valid && !r_skid_valid;

         // Skid only fills while main is stalled, so it drains first whenever main frees up.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               r_main_valid <= 1'b0;
               r_skid_valid <= 1'b0;
               r_in_ready   <= 1'b0;
            end else if (w_main_load) begin
               r_main_valid <= r_skid_valid || w_accept;
               r_skid_valid <= 1'b0;
               r_in_ready   <= 1'b1;
            end else if (w_accept) begin
               r_skid_valid <= 1'b1;
               r_in_ready   <= 1'b0;
            end
         end

         always_ff @(posedge aclk) begin
            if (w_main_load)   r_main_data <= r_skid_valid ? r_skid_data : in_data;
            else if (w_accept) r_skid_data <= in_data;
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_register_slice_param.sv
`default_nettype none
// ============================================================================
// Module : axi_register_slice_param
// Desc   : AXI4 register slice with per-channel mode and NUM_STAGES-deep cascade.
// Rev    : 1.0 - initial release
// ============================================================================
module axi_register_slice_param #(
   parameter int ID_W       = 6,
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 512,
   parameter int AW_MODE    = 2,
   parameter int W_MODE     = 2,
   parameter int B_MODE     = 1,
   parameter int AR_MODE    = 2,
   parameter int R_MODE     = 2,
   parameter int NUM_STAGES = 1
) (
   input  wire   aclk,
   input  wire   aresetn,
   axi_if.slave  s_axi,
   axi_if.master m_axi,
   output logic  idle
);
   import axi_slice_pkg::*;

   localparam int c_aw_w = payload_w(CH_AW, ID_W, ADDR_W, DATA_W);
   localparam int c_w_w  = payload_w(CH_W,  ID_W, ADDR_W, DATA_W);
   localparam int c_b_w  = payload_w(CH_B,  ID_W, ADDR_W, DATA_W);
   localparam int c_ar_w = payload_w(CH_AR, ID_W, ADDR_W, DATA_W);
   localparam int c_r_w  = payload_w(CH_R,  ID_W, ADDR_W, DATA_W);

   // Index 0 is the upstream end of each chain, index NUM_STAGES the downstream end.
   logic              w_aw_v [NUM_STAGES+1], w_aw_r [NUM_STAGES+1];
   logic [c_aw_w-1:0] w_aw_d [NUM_STAGES+1];
   logic              w_w_v  [NUM_STAGES+1], w_w_r  [NUM_STAGES+1];
   logic [c_w_w-1:0]  w_w_d  [NUM_STAGES+1];
   logic              w_b_v  [NUM_STAGES+1], w_b_r  [NUM_STAGES+1];
   logic [c_b_w-1:0]  w_b_d  [NUM_STAGES+1];
   logic              w_ar_v [NUM_STAGES+1], w_ar_r [NUM_STAGES+1];
   logic [c_ar_w-1:0] w_ar_d [NUM_STAGES+1];
   logic              w_r_v  [NUM_STAGES+1], w_r_r  [NUM_STAGES+1];
   logic [c_r_w-1:0]  w_r_d  [NUM_STAGES+1];
   logic [NUM_STAGES-1:0] w_aw_e, w_w_e, w_b_e, w_ar_e, w_r_e;

   assign w_aw_v[0] = s_axi.awvalid;
   assign w_aw_d[0] = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize};
   assign s_axi.awready = w_aw_r[0];
   assign m_axi.awvalid = w_aw_v[NUM_STAGES];
   assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize} = w_aw_d[NUM_STAGES];
   assign w_aw_r[NUM_STAGES] = m_axi.awready;

   assign w_w_v[0] = s_axi.wvalid;
   assign w_w_d[0] = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
   assign s_axi.wready = w_w_r[0];
   assign m_axi.wvalid = w_w_v[NUM_STAGES];
   assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_w_d[NUM_STAGES];
   assign w_w_r[NUM_STAGES] = m_axi.wready;

   // Response channels run downstream-to-upstream.
   assign w_b_v[0] = m_axi.bvalid;
   assign w_b_d[0] = {m_axi.bid, m_axi.bresp};
   assign m_axi.bready = w_b_r[0];
   assign s_axi.bvalid = w_b_v[NUM_STAGES];
   assign {s_axi.bid, s_axi.bresp} = w_b_d[NUM_STAGES];
   assign w_b_r[NUM_STAGES] = s_axi.bready;

   assign w_ar_v[0] = s_axi.arvalid;
   assign w_ar_d[0] = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize};
   assign s_axi.arready = w_ar_r[0];
   assign m_axi.arvalid = w_ar_v[NUM_STAGES];
   assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize} = w_ar_d[NUM_STAGES];
   assign w_ar_r[NUM_STAGES] = m_axi.arready;

   assign w_r_v[0] = m_axi.rvalid;
   assign w_r_d[0] = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
   assign m_axi.rready = w_r_r[0];
   assign s_axi.rvalid = w_r_v[NUM_STAGES];
   assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = w_r_d[NUM_STAGES];
   assign w_r_r[NUM_STAGES] = s_axi.rready;

   generate
      for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
         axi_reg_stage #(.PAYLOAD_W(c_aw_w), .MODE(AW_MODE)) u_aw (
            .aclk(aclk), .aresetn(aresetn),
            .in_valid(w_aw_v[i]), .in_ready(w_aw_r[i]), .in_data(w_aw_d[i]),
            .out_valid(w_aw_v[i+1]), .out_ready(w_aw_r[i+1]), .out_data(w_aw_d[i+1]),
            .empty(w_aw_e[i]));
         axi_reg_stage #(.PAYLOAD_W(c_w_w), .MODE(W_MODE)) u_w (
            .aclk(aclk), .aresetn(aresetn),
            .in_valid(w_w_v[i]), .in_ready(w_w_r[i]), .in_data(w_w_d[i]),
            .out_valid(w_w_v[i+1]), .out_ready(w_w_r[i+1]), .out_data(w_w_d[i+1]),
            .empty(w_w_e[i]));
         axi_reg_stage #(.PAYLOAD_W(c_b_w), .MODE(B_MODE)) u_b (
            .aclk(aclk), .aresetn(aresetn),
            .in_valid(w_b_v[i]), .in_ready(w_b_r[i]), .in_data(w_b_d[i]),
            .out_valid(w_b_v[i+1]), .out_ready(w_b_r[i+1]), .out_data(w_b_d[i+1]),
            .empty(w_b_e[i]));
         axi_reg_stage #(.PAYLOAD_W(c_ar_w), .MODE(AR_MODE)) u_ar (
            .aclk(aclk), .aresetn(aresetn),
            .in_valid(w_ar_v[i]), .in_ready(w_ar_r[i]), .in_data(w_ar_d[i]),
            .out_valid(w_ar_v[i+1]), .out_ready(w_ar_r[i+1]), .out_data(w_ar_d[i+1]),
            .empty(w_ar_e[i]));
         axi_reg_stage #(.PAYLOAD_W(c_r_w), .MODE(R_MODE)) u_r (
            .aclk(aclk), .aresetn(aresetn),
            .in_valid(w_r_v[i]), .in_ready(w_r_r[i]), .in_data(w_r_d[i]),
            .out_valid(w_r_v[i+1]), .out_ready(w_r_r[i+1]), .out_data(w_r_d[i+1]),
            .empty(w_r_e[i]));
      end
   endgenerate

   assign idle = &{w_aw_e, w_w_e, w_b_e, w_ar_e, w_r_e};

endmodule
`default_nettype wire

// File: tb/tb_axi_register_slice_param.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_register_slice_param
// Desc   : Self-checking bench: mixed-mode single-stage slice plus 3-deep skid slice.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axi_register_slice_param;

   logic aclk, aresetn, idle0, idle1;
   int   checks, failures;

   axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(64)) s0 ();
   axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(64)) m0 ();
   axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(64)) s1 ();
   axi_if #(.ID_W(6), .ADDR_W(32), .DATA_W(64)) m1 ();

   axi_register_slice_param #(
      .ID_W(6), .ADDR_W(32), .DATA_W(64),
      .AW_MODE(2), .W_MODE(2), .B_MODE(0), .AR_MODE(1), .R_MODE(2), .NUM_STAGES(1)
   ) u_dut0 (.aclk(aclk), .aresetn(aresetn), .s_axi(s0), .m_axi(m0), .idle(idle0));

   axi_register_slice_param #(
      .ID_W(6), .ADDR_W(32), .DATA_W(64),
      .AW_MODE(2), .W_MODE(2), .B_MODE(2), .AR_MODE(2), .R_MODE(2), .NUM_STAGES(3)
   ) u_dut1 (.aclk(aclk), .aresetn(aresetn), .s_axi(s1), .m_axi(m1), .idle(idle1));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic        mr;
      logic        exp_sr;
      logic        exp_mv;
      logic [31:0] exp_addr;
   } ar_vec_t;

   typedef struct {
      logic [5:0] bid;
      logic [1:0] bresp;
      logic       bvalid;
      logic       bready;
      logic [5:0] exp_bid;
      logic [1:0] exp_bresp;
      logic       exp_bvalid;
      logic       exp_bready;
   } b_vec_t;

   ar_vec_t    ar_tbl[8];
   b_vec_t     b_tbl[4];
   logic [72:0] wq[$];
   logic [72:0] rq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [72:0] w_in();
      return {s0.wdata, s0.wstrb, s0.wlast};
   endfunction
   function automatic logic [72:0] w_out();
      return {m0.wdata, m0.wstrb, m0.wlast};
   endfunction
   function automatic logic [72:0] r_in();
      return {m1.rid, m1.rdata, m1.rresp, m1.rlast};
   endfunction
   function automatic logic [72:0] r_out();
      return {s1.rid, s1.rdata, s1.rresp, s1.rlast};
   endfunction

   task automatic drive_w_rand();
      s0.wdata = {$urandom, $urandom};
      s0.wstrb = 8'($urandom);
      s0.wlast = 1'($urandom);
   endtask

   initial begin
      logic [31:0] cur_addr;
      logic [72:0] exp_beat, held;
      logic        acc, stall;
      int          n, drops;

      checks = 0; failures = 0;
      aresetn = 1'b0;
      s0.awid = '0; s0.awaddr = '0; s0.awlen = '0; s0.awsize = '0; s0.awvalid = 1'b0;
      s0.wdata = '0; s0.wstrb = '0; s0.wlast = 1'b0; s0.wvalid = 1'b0; s0.bready = 1'b0;
      s0.arid = '0; s0.araddr = '0; s0.arlen = '0; s0.arsize = '0; s0.arvalid = 1'b0;
      s0.rready = 1'b0;
      m0.awready = 1'b0; m0.wready = 1'b0; m0.arready = 1'b0;
      m0.bid = '0; m0.bresp = '0; m0.bvalid = 1'b0;
      m0.rid = '0; m0.rdata = '0; m0.rresp = '0; m0.rlast = 1'b0; m0.rvalid = 1'b0;
      s1.awid = '0; s1.awaddr = '0; s1.awlen = '0; s1.awsize = '0; s1.awvalid = 1'b0;
      s1.wdata = '0; s1.wstrb = '0; s1.wlast = 1'b0; s1.wvalid = 1'b0; s1.bready = 1'b0;
      s1.arid = '0; s1.araddr = '0; s1.arlen = '0; s1.arsize = '0; s1.arvalid = 1'b0;
      s1.rready = 1'b0;
      m1.awready = 1'b0; m1.wready = 1'b0; m1.arready = 1'b0;
      m1.bid = '0; m1.bresp = '0; m1.bvalid = 1'b0;
      m1.rid = '0; m1.rdata = '0; m1.rresp = '0; m1.rlast = 1'b0; m1.rvalid = 1'b0;

      // AR forward stage, s_arvalid held high, m_arready pattern per row
      ar_tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000};
      ar_tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h1000};
      ar_tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h1040};
      ar_tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h1040};
      ar_tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h1080};
      ar_tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h1080};
      ar_tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h10C0};
      ar_tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h1100};
      b_tbl[0]  = '{6'h15, 2'b10, 1'b1, 1'b1, 6'h15, 2'b10, 1'b1, 1'b1};
      b_tbl[1]  = '{6'h2A, 2'b01, 1'b1, 1'b0, 6'h2A, 2'b01, 1'b1, 1'b0};
      b_tbl[2]  = '{6'h3F, 2'b11, 1'b0, 1'b1, 6'h3F, 2'b11, 1'b0, 1'b1};
      b_tbl[3]  = '{6'h00, 2'b00, 1'b1, 1'b1, 6'h00, 2'b00, 1'b1, 1'b1};

      // ---- reset state ----
      step(); step();
      check("rst_m_awvalid", m0.awvalid, 0);
      check("rst_m_wvalid", m0.wvalid, 0);
      check("rst_m_arvalid", m0.arvalid, 0);
      check("rst_s_rvalid", s0.rvalid, 0);
      check("rst_s1_rvalid", s1.rvalid, 0);
      check("rst_s_wready_low", s0.wready, 0);
      check("rst_idle0", idle0, 1);
      check("rst_idle1", idle1, 1);
      #2 aresetn = 1'b1;
      step();
      check("rst_s_wready_rise", s0.wready, 1);

      // ---- B bypass table ----
      foreach (b_tbl[i]) begin
         m0.bid = b_tbl[i].bid; m0.bresp = b_tbl[i].bresp;
         m0.bvalid = b_tbl[i].bvalid; s0.bready = b_tbl[i].bready;
         #1;
         check("byp_bvalid", s0.bvalid, b_tbl[i].exp_bvalid);
         check("byp_bid", s0.bid, b_tbl[i].exp_bid);
         check("byp_bresp", s0.bresp, b_tbl[i].exp_bresp);
         check("byp_bready", m0.bready, b_tbl[i].exp_bready);
         check("byp_idle", idle0, 1);
         step();
      end
      m0.bvalid = 1'b0;

      // ---- AR forward table ----
      cur_addr = 32'h1000;
      s0.arvalid = 1'b1;
      foreach (ar_tbl[i]) begin
         m0.arready = ar_tbl[i].mr;
         s0.araddr = cur_addr;
         #1;
         check("fwd_arready", s0.arready, ar_tbl[i].exp_sr);
         check("fwd_ready_rule", s0.arready, m0.arready || !m0.arvalid);
         check("fwd_arvalid", m0.arvalid, ar_tbl[i].exp_mv);
         if (ar_tbl[i].exp_mv) check("fwd_araddr", m0.araddr, ar_tbl[i].exp_addr);
         if (s0.arvalid && s0.arready) cur_addr = cur_addr + 32'h40;
         step();
      end
      s0.arvalid = 1'b0; m0.arready = 1'b1;
      step(); step();
      check("fwd_drained_idle", idle0, 1);

      // ---- W streaming, 256 beats ----
      m0.wready = 1'b1;
      drops = 0;
      for (int i = 0; i <= 256; i++) begin
         if (i < 256) begin
            drive_w_rand(); s0.wvalid = 1'b1;
         end else s0.wvalid = 1'b0;
         #1;
         if (i == 0) check("stream_first_lat0", m0.wvalid, 0);
         else begin
            check("stream_valid", m0.wvalid, 1);
            exp_beat = (wq.size() > 0) ? wq.pop_front() : 73'h0;
            check("stream_data", w_out(), exp_beat);
         end
         if (i < 256) begin
            if (!s0.wready) drops++;
            wq.push_back(w_in());
         end
         step();
      end
      check("stream_wready_never_drops", drops, 0);
      check("stream_drained", m0.wvalid, 0);

      // ---- backpressure: 5 stalled cycles ----
      m0.wready = 1'b0; s0.wvalid = 1'b1; drive_w_rand();
      n = 0; held = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c >= 2) check("bp_m_wdata_stable", w_out(), held);
         held = w_out();
         acc = s0.wready;
         if (acc) begin wq.push_back(w_in()); n++; end
         step();
         if (acc) drive_w_rand();
      end
      check("bp_accepted", n, 2);
      check("bp_wready_low", s0.wready, 0);
      s0.wvalid = 1'b0; m0.wready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (m0.wvalid) begin
            exp_beat = (wq.size() > 0) ? wq.pop_front() : 73'h0;
            check("bp_drain_data", w_out(), exp_beat);
         end
         step();
      end
      check("bp_no_loss", wq.size(), 0);

      // ---- randomized W traffic against occupancy/queue model ----
      acc = 1'b0; stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (acc || !s0.wvalid) begin
            s0.wvalid = ($urandom_range(0, 3) != 0);
            drive_w_rand();
         end
         m0.wready = ($urandom_range(0, 2) != 0);
         #1;
         check("rnd_wready_occ", s0.wready, wq.size() < 2);
         check("rnd_wvalid_occ", m0.wvalid, wq.size() > 0);
         if (stall) check("rnd_held_stable", w_out(), held);
         if (m0.wvalid && m0.wready) begin
            exp_beat = (wq.size() > 0) ? wq.pop_front() : 73'h0;
            check("rnd_data", w_out(), exp_beat);
         end
         stall = m0.wvalid && !m0.wready;
         held = w_out();
         acc = s0.wvalid && s0.wready;
         if (acc) wq.push_back(w_in());
         step();
      end
      s0.wvalid = 1'b0; m0.wready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (m0.wvalid) begin
            exp_beat = (wq.size() > 0) ? wq.pop_front() : 73'h0;
            check("rnd_drain_data", w_out(), exp_beat);
         end
         step();
      end
      check("rnd_no_loss", wq.size(), 0);

      // ---- reset mid-burst with 4 beats buffered ----
      m0.wready = 1'b0; m0.awready = 1'b0;
      s0.wvalid = 1'b1; s0.awvalid = 1'b1; drive_w_rand(); s0.awaddr = 32'hDEAD_0000;
      step();
      drive_w_rand(); s0.awaddr = 32'hDEAD_0040;
      step();
      s0.wvalid = 1'b0; s0.awvalid = 1'b0;
      check("mid_buffered_not_idle", idle0, 0);
      check("mid_skid_full", s0.wready, 0);
      #2 aresetn = 1'b0;
      #1;
      check("mid_rst_wvalid", m0.wvalid, 0);
      check("mid_rst_awvalid", m0.awvalid, 0);
      check("mid_rst_idle", idle0, 1);
      @(posedge aclk);
      #4 aresetn = 1'b1;
      #1;
      check("mid_wready_before_edge", s0.wready, 0);
      step();
      check("mid_wready_first_edge", s0.wready, 1);
      m0.wready = 1'b1; m0.awready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("mid_no_stale_w", m0.wvalid, 0);
         check("mid_no_stale_aw", m0.awvalid, 0);
         step();
      end
      wq.delete();

      // ---- cascade: 3-stage R latency ----
      s1.rready = 1'b1;
      m1.rid = 6'd3; m1.rlast = 1'b1; m1.rresp = 2'b00; m1.rdata = {$urandom, $urandom};
      m1.rvalid = 1'b1;
      #1;
      check("casc_in_ready", m1.rready, 1);
      exp_beat = r_in();
      step();
      m1.rvalid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         #1;
         check("casc_latency_rvalid", s1.rvalid, k == 3);
         if (k == 3) check("casc_beat", r_out(), exp_beat);
         step();
      end
      #1;
      check("casc_single_beat", s1.rvalid, 0);
      step();

      // ---- cascade capacity under stall ----
      s1.rready = 1'b0; m1.rvalid = 1'b1;
      m1.rid = 6'd0; m1.rdata = {$urandom, $urandom}; m1.rresp = 2'($urandom); m1.rlast = 1'b0;
      n = 0;
      for (int c = 0; c < 16; c++) begin
         #1;
         acc = m1.rready;
         if (acc) begin rq.push_back(r_in()); n++; end
         step();
         if (acc) begin
            m1.rid = 6'(n); m1.rdata = {$urandom, $urandom};
            m1.rresp = 2'($urandom); m1.rlast = 1'($urandom);
         end
      end
      check("casc_capacity", n, 6);
      check("casc_full_ready_low", m1.rready, 0);
      m1.rvalid = 1'b0; s1.rready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (s1.rvalid) begin
            exp_beat = (rq.size() > 0) ? rq.pop_front() : 73'h0;
            check("casc_order", r_out(), exp_beat);
         end
         step();
      end
      check("casc_no_loss", rq.size(), 0);
      check("casc_idle", idle1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_register_slice_param.md
Name: axi_register_slice_param

Overview:
- Parametrised AXI4 register slice with independent per-channel modes and a configurable cascade depth.
- Sits between PCIe/DMA (dma_pcis) masters and the PairHMM accelerator fabric; breaks timing paths on long SLR crossings.
- Generalises the fixed single-mode slice: configurable widths, per-channel bypass, forward-register or full-skid operation, N stages, and an idle status output.

Parameters:
ID_W, 6, AXI ID width for aw/b/ar/r
ADDR_W, 64, address width for aw/ar
DATA_W, 512, data width for w/r; STRB_W = DATA_W/8; must be a power of two, at least 32
AW_MODE, 2, 0=bypass, 1=forward register, 2=full skid
W_MODE, 2, mode for the W channel
B_MODE, 1, mode for the B channel
AR_MODE, 2, mode for the AR channel
R_MODE, 2, mode for the R channel
NUM_STAGES, 1, number of cascaded stages per non-bypass channel, range 1..4

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
s_axi  axi_if.slave  iface  upstream AXI4 port; interface widths must equal ID_W/ADDR_W/DATA_W
m_axi  axi_if.master  iface  downstream AXI4 port; same widths as s_axi
idle  output  1  high when every stage of every channel is empty

Behaviour:
- Channel payloads, packed MSB to LSB:
  - AW = {awid, awaddr, awlen[7:0], awsize[2:0]}
  - W = {wdata, wstrb, wlast}
  - B = {bid, bresp[1:0]}
  - AR = {arid, araddr, arlen, arsize}
  - R = {rid, rdata, rresp, rlast}
- Direction: AW/W/AR flow s→m; B/R flow m→s.
- Transfers occur on valid&&ready at the rising edge. Payload must be passed bit-exact, and beat order must be preserved.
- Mode 0 (bypass): pure wires, 0 latency, no state. NUM_STAGES is ignored.
- Mode 1 (forward):
  - Registers valid and payload; ready is combinational: in_ready = out_ready || !out_valid.
  - Latency is 1 cycle per stage; 100% throughput.
- Mode 2 (full skid):
  - Holds a main register and a skid register; in_ready = !skid_valid, and it is registered.
  - Accept with main full and !out_ready → load skid.
  - out_ready with skid full → main <= skid, skid cleared.
  - out_ready with skid empty → main <= incoming beat, or invalid if none.
  - Latency is 1 cycle per stage; 100% throughput with no combinational ready path; at most 2 beats held per stage.
- Cascade: NUM_STAGES identical stages per channel. Latency = NUM_STAGES cycles; capacity = NUM_STAGES×(1 or 2) beats.
- Reset (aresetn low, asynchronous):
  - All valid outputs (m_axi aw/w/ar valid, s_axi b/r valid) go 0 immediately.
  - Skid-mode in_ready is 0 during reset and rises on the first clock edge after deassertion.
  - idle = 1.
  - Payload registers are not reset (don't-care while valid=0).
- Reset mid-transfer: all in-flight beats are dropped; no beat may appear after reset release unless it is newly accepted.
- Simultaneous accept and emit on a full-skid stage holding one beat: main is replaced, skid stays empty, no bubble.
- Held-valid rule: once out_valid=1, payload must stay stable until out_ready.
- idle = AND of !valid over all main and skid registers. It is registered-derived, with no combinational path from inputs.

Decomposition:
- Package axi_slice_pkg:
  - typedef slice_mode_e {SLC_BYPASS, SLC_FWD, SLC_FULL}
  - localparams AXI_LEN_W=8, AXI_SIZE_W=3, AXI_RESP_W=2
  - function payload_w(channel, ID_W, ADDR_W, DATA_W)
- Sub-module axi_reg_stage:
  - Parameters PAYLOAD_W, MODE.
  - Ports aclk, aresetn, in_valid/in_ready/in_data, out_valid/out_ready/out_data, empty.
- The top instantiates a generate loop of stages per channel and packs/unpacks the interface signals.

Test Plan:
- Streaming, all channels in mode 2, NUM_STAGES=1: 256 W beats with m_wready=1 continuously → m_wvalid first high 1 cycle after the first s_wvalid; one beat per cycle; data matches the scoreboard; s_wready never drops.
- Backpressure on mode 2: m_wready=0 for 5 cycles while s_wvalid=1 → stage accepts exactly 2 beats, then s_wready=0. On release, beats emerge in order with no loss or duplication; m_wdata is stable while stalled.
- Forward mode, AR_MODE=1: m_arready toggles with a 1/0 pattern → s_arready equals (m_arready || !m_arvalid) combinationally; araddr sequence 0x1000, 0x1040, … preserved.
- Bypass, B_MODE=0: bid=0x15, bresp=2'b10 → appears on s_axi in the same cycle; idle is unaffected.
- Cascade, NUM_STAGES=3, mode 2, R channel: single beat rid=3, rlast=1 → s_rvalid is asserted exactly 3 cycles after m_rvalid; capacity under stall = 6 beats.
- Reset mid-burst: assert aresetn low with 4 beats buffered, between clock edges → all valids drop asynchronously and idle=1. After release, s_wready=1 on the first edge and no stale beat is emitted.
